// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that merges pipeline and multi-cycle writebacks onto the single register-file write port.
// Define RF_WB_FWD_EN to add combinational forwarding of the in-flight write to the two read ports.
module regfile_wb_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wb0_valid,
  input  logic [AW-1:0] wb0_addr,
  input  logic [DW-1:0] wb0_data,
  output logic          wb0_ready,
  input  logic          wb1_valid,
  input  logic [AW-1:0] wb1_addr,
  input  logic [DW-1:0] wb1_data,
  output logic          wb1_ready,
  output logic          WE3,
  output logic [AW-1:0] A3,
  output logic [DW-1:0] WD3,
  output logic          busy
`ifdef RF_WB_FWD_EN
  ,
  input  logic [AW-1:0] rd_a1,
  input  logic [AW-1:0] rd_a2,
  input  logic [DW-1:0] rf_rd1,
  input  logic [DW-1:0] rf_rd2,
  output logic [DW-1:0] fwd_rd1,
  output logic [DW-1:0] fwd_rd2
`endif
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;

  logic    prio;
  logic    gnt0, gnt1, xfer;
  wb_req_t req0, req1, sel;

  assign req0 = '{addr: wb0_addr, data: wb0_data};
  assign req1 = '{addr: wb1_addr, data: wb1_data};

  // Grants are held low while reset is asserted so requesters cannot handshake.
  assign gnt0 = reset_n & wb0_valid & (~wb1_valid | ~prio);
  assign gnt1 = reset_n & wb1_valid & (~wb0_valid |  prio);
  assign xfer = gnt0 | gnt1;
  assign sel  = gnt1 ? req1 : req0;

  assign wb0_ready = gnt0;
  assign wb1_ready = gnt1;
  assign busy      = reset_n & ((wb0_valid & ~gnt0) | (wb1_valid & ~gnt1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio <= 1'b0;
      WE3  <= 1'b0;
      A3   <= '0;
      WD3  <= '0;
    end else if (xfer) begin
      // Point at the loser; register-0 writes still rotate priority.
      prio <= gnt0;
      WE3  <= (sel.addr != '0);
      A3   <= sel.addr;
      WD3  <= sel.data;
    end else begin
      WE3  <= 1'b0;
    end
  end

`ifdef RF_WB_FWD_EN
  logic [1:0][AW-1:0] rd_a;
  logic [1:0][DW-1:0] rf_rd;
  logic [1:0][DW-1:0] fwd_rd;

  assign rd_a  = {rd_a2, rd_a1};
  assign rf_rd = {rf_rd2, rf_rd1};

  for (genvar k = 0; k < 2; k++) begin : g_fwd
    assign fwd_rd[k] = (WE3 && (A3 == rd_a[k]) && (rd_a[k] != '0)) ? WD3 : rf_rd[k];
  end

  assign fwd_rd1 = fwd_rd[0];
  assign fwd_rd2 = fwd_rd[1];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic against a
// grant-order reference model and a shadow register file fed from the write port.
module tb_regfile_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          v0, v1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;
  logic          wb0_ready, wb1_ready, WE3, busy;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD3;

  always #5 clk = ~clk;

  // Shadow register file driven by the DUT write port; expected contents driven by the model.
  logic [DW-1:0] dut_ram [32];
  logic [DW-1:0] ref_ram [32];
  always @(posedge clk) if (WE3 === 1'b1) dut_ram[A3] <= WD3;

`ifdef RF_WB_FWD_EN
  logic [AW-1:0] rd_a1, rd_a2;
  logic [DW-1:0] rf_rd1, rf_rd2, fwd_rd1, fwd_rd2;
  assign rf_rd1 = dut_ram[rd_a1];
  assign rf_rd2 = dut_ram[rd_a2];
`endif

  regfile_wb_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb0_valid(v0), .wb0_addr(a0), .wb0_data(d0), .wb0_ready(wb0_ready),
    .wb1_valid(v1), .wb1_addr(a1), .wb1_data(d1), .wb1_ready(wb1_ready),
    .WE3(WE3), .A3(A3), .WD3(WD3), .busy(busy)
`ifdef RF_WB_FWD_EN
    , .rd_a1(rd_a1), .rd_a2(rd_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .fwd_rd1(fwd_rd1), .fwd_rd2(fwd_rd2)
`endif
  );

  int vecs = 0;
  int errs = 0;

  // Reference state: preferred source after contention and the expected port contents.
  bit            m_pref1;
  bit            m_we;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d;
  int            last_src;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pref1 = 1'b0; m_we = 1'b0; m_a = '0; m_d = '0;
  endtask

  // One clock: check combinational handshake outputs mid-cycle, then the registered port after the edge.
  task automatic cyc();
    bit            g0, g1;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    @(negedge clk);
    g0 = 1'b0; g1 = 1'b0;
    if (reset_n) begin
      if (v0 && v1) begin g0 = !m_pref1; g1 = m_pref1; end
      else begin g0 = v0; g1 = v1; end
    end
    check("wb0_ready", wb0_ready, g0);
    check("wb1_ready", wb1_ready, g1);
    check("busy", busy, reset_n && ((v0 && !g0) || (v1 && !g1)));
`ifdef RF_WB_FWD_EN
    check("fwd_rd1", fwd_rd1, (m_we && m_a == rd_a1 && rd_a1 != 0) ? m_d : dut_ram[rd_a1]);
    check("fwd_rd2", fwd_rd2, (m_we && m_a == rd_a2 && rd_a2 != 0) ? m_d : dut_ram[rd_a2]);
`endif
    @(posedge clk);
    #1;
    last_src = -1;
    if (g0 || g1) begin
      ga = g0 ? a0 : a1;
      gd = g0 ? d0 : d1;
      m_we = (ga != 0);
      m_a = ga;
      m_d = gd;
      m_pref1 = g0;
      if (ga != 0) ref_ram[ga] = gd;
      last_src = g0 ? 0 : 1;
      if (g0) v0 = 1'b0; else v1 = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    check("WE3", WE3, m_we);
    check("A3", A3, m_a);
    check("WD3", WD3, m_d);
  endtask

  initial begin
    int n0, n1, w0, w1, prev;
    logic [DW-1:0] old7;
    reset_n = 1'b0;
    v0 = 1'b1; a0 = 5'd3; d0 = 32'h1111_0003;
    v1 = 1'b1; a1 = 5'd4; d1 = 32'h2222_0004;
`ifdef RF_WB_FWD_EN
    rd_a1 = 5'd3; rd_a2 = 5'd4;
`endif
    for (int i = 0; i < 32; i++) begin dut_ram[i] = '0; ref_ram[i] = '0; end
    model_reset();

    // Reset with both valids high, then wb0 must win first.
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
    check("first_grant_wb0", last_src, 0);
    cyc();
    check("second_grant_wb1", last_src, 1);
    cyc();

    // Lone pipeline write.
    v0 = 1'b1; a0 = 5'd5; d0 = 32'hDEAD_BEEF;
    cyc();
    check("wb0_alone_we", WE3, 1'b1);
    cyc();
    check("wb0_alone_we_clear", WE3, 1'b0);

    // Continuous contention: four requests each, alternating grants, waits at most one cycle.
    n0 = 0; n1 = 0; w0 = 0; w1 = 0; prev = -1;
    for (int c = 0; c < 12 && (n0 < 4 || n1 < 4 || v0 || v1); c++) begin
      if (!v0 && n0 < 4) begin v0 = 1'b1; a0 = 5'(10 + n0); d0 = 32'hA000_0000 + n0; n0++; end
      if (!v1 && n1 < 4) begin v1 = 1'b1; a1 = 5'(20 + n1); d1 = 32'hB000_0000 + n1; n1++; end
      cyc();
      w0 = v0 ? w0 + 1 : 0;
      w1 = v1 ? w1 + 1 : 0;
      check("wait0_le1", w0 <= 1, 1'b1);
      check("wait1_le1", w1 <= 1, 1'b1);
      if (prev >= 0 && last_src >= 0 && (v0 || v1 || n0 < 4 || n1 < 4))
        check("alternate", last_src != prev, 1'b1);
      if (last_src >= 0) prev = last_src;
    end
    check("contention_drained", v0 || v1, 1'b0);

    // Register-0 write: accepted, no WE3.
    v1 = 1'b1; a1 = 5'd0; d1 = 32'h1234;
    cyc();
    check("r0_accepted", last_src, 1);
    check("r0_no_we", WE3, 1'b0);

    // Make wb1 preferred, then both target register 9.
    v0 = 1'b1; a0 = 5'd1; d0 = 32'h0101_0101;
    cyc();
    v0 = 1'b1; a0 = 5'd9; d0 = 32'hA;
    v1 = 1'b1; a1 = 5'd9; d1 = 32'hB;
    cyc();
    check("same_addr_first_wb1", last_src, 1);
    cyc();
    check("same_addr_then_wb0", last_src, 0);
    cyc();
    check("ram9_final", dut_ram[9], 32'hA);

    // Random traffic.
    for (int c = 0; c < 300; c++) begin
      if (!v0 && ($urandom_range(0, 2) != 0)) begin
        v0 = 1'b1; a0 = 5'($urandom_range(0, 31)); d0 = $urandom;
      end
      if (!v1 && ($urandom_range(0, 2) != 0)) begin
        v1 = 1'b1; a1 = 5'($urandom_range(0, 31)); d1 = $urandom;
      end
`ifdef RF_WB_FWD_EN
      rd_a1 = ($urandom_range(0, 1) != 0) ? m_a : 5'($urandom_range(0, 31));
      rd_a2 = 5'($urandom_range(0, 31));
`endif
      cyc();
    end
    for (int c = 0; c < 4 && (v0 || v1); c++) cyc();
    check("random_drained", v0 || v1, 1'b0);
    cyc();
    for (int i = 0; i < 32; i++) check($sformatf("ram[%0d]", i), dut_ram[i], ref_ram[i]);

    // Write to 7 then reset in the following cycle: write is discarded.
    old7 = dut_ram[7];
    v0 = 1'b1; a0 = 5'd7; d0 = 32'h55;
    cyc();
    check("w7_we", WE3, 1'b1);
`ifdef RF_WB_FWD_EN
    rd_a1 = 5'd7; rd_a2 = 5'd0;
    #1;
    check("fwd7_new", fwd_rd1, 32'h55);
    check("rf7_stale", rf_rd1, old7);
    check("fwd_r0_passthru", fwd_rd2, rf_rd2);
`endif
    reset_n = 1'b0;
    #1;
    model_reset();
    ref_ram[7] = old7;
    check("rst_we_async", WE3, 1'b0);
    check("rst_a3_async", A3, '0);
`ifdef RF_WB_FWD_EN
    check("rst_fwd_revert", fwd_rd1, old7);
`endif
    cyc();
    check("w7_discarded", dut_ram[7], old7);
    reset_n = 1'b1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", vecs);
    $fatal(1);
  end
endmodule
